turn_controller: RTL and testbench

Sequences turns in the Triangles vs Circles game and shares the single coordinate input handler between the two players. It accepts a validated coordinate pulse, range-checks it, and reads the board cell to check occupancy. It then commits the current player's mark to board memory or rejects the move, alternates players, counts moves and declares game over at the move limit.

---
 rtl/turn_controller.sv | 135 +++++++++++++
 tb/tb_turn_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/turn_controller.sv
// turn_controller: sequences Triangles vs Circles turns, validates moves against the board and commits marks
// Ports: clk/reset (async active-low); start begins a game; coord_valid/x_in/y_in carry a move;
// brd_rd_* read the addressed cell; brd_we/brd_wr_* commit a mark; current_player, move_accepted,
// move_rejected, tri_moves, cir_moves, game_over, timeout and fsm_state report progress.
// Optional macro TURN_TIMEOUT_EN adds a per-turn timer that passes the turn after TIMEOUT_CYCLES.
module turn_controller #(
  parameter int BOARD_DIM = 10,
  parameter int MOVE_LIMIT = 25,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       coord_valid,
  input  logic [3:0] x_in,
  input  logic [3:0] y_in,
  output logic [3:0] brd_rd_x,
  output logic [3:0] brd_rd_y,
  input  logic [1:0] brd_rd_data,
  output logic       brd_we,
  output logic [3:0] brd_wr_x,
  output logic [3:0] brd_wr_y,
  output logic [1:0] brd_wr_data,
  output logic       current_player,
  output logic       move_accepted,
  output logic       move_rejected,
  output logic [4:0] tri_moves,
  output logic [4:0] cir_moves,
  output logic       game_over,
  output logic       timeout,
  output logic [2:0] fsm_state
);
  typedef enum logic [2:0] {IDLE = 3'd0, WAIT_COORD = 3'd1, CHECK = 3'd2, DECIDE = 3'd3, DONE = 3'd4} state_t;
  localparam logic [4:0] DIM = 5'(BOARD_DIM);
  localparam logic [4:0] LIM = 5'(MOVE_LIMIT);
  state_t state, state_nx;
  logic [3:0] rd_x_nx, rd_y_nx, wr_x_nx, wr_y_nx;
  logic [1:0] wr_data_nx;
  logic       we_nx, acc_nx, rej_nx, player_nx, legal;
  logic [4:0] tri_nx, cir_nx;
  assign legal = ({1'b0, brd_rd_x} < DIM) && ({1'b0, brd_rd_y} < DIM) && (brd_rd_data == 2'b00);
  assign game_over = state == DONE;
  assign fsm_state = state;
`ifdef TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] RELOAD = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmr;
  logic          expire;
  // coord_valid in the expiry cycle wins, so the turn is not passed
  assign expire = state == WAIT_COORD && !coord_valid && tmr == '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tmr <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= expire;
      tmr <= (state_nx == WAIT_COORD && (state != WAIT_COORD || expire)) ? RELOAD
           : (state == WAIT_COORD) ? tmr - TW'(1) : tmr;
    end
`else
  logic expire;
  assign expire = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    rd_x_nx = brd_rd_x;
    rd_y_nx = brd_rd_y;
    wr_x_nx = brd_wr_x;
    wr_y_nx = brd_wr_y;
    wr_data_nx = brd_wr_data;
    we_nx = 1'b0;
    acc_nx = 1'b0;
    rej_nx = 1'b0;
    player_nx = current_player ^ expire;
    tri_nx = tri_moves;
    cir_nx = cir_moves;
    case (state)
      IDLE, DONE: if (start) begin
        state_nx = WAIT_COORD;
        tri_nx = '0;
        cir_nx = '0;
        player_nx = 1'b0;
      end
      WAIT_COORD: if (coord_valid) begin
        state_nx = CHECK;
        rd_x_nx = x_in;
        rd_y_nx = y_in;
      end
      CHECK: state_nx = DECIDE;
      DECIDE: begin
        if (legal) begin
          we_nx = 1'b1;
          acc_nx = 1'b1;
          wr_x_nx = brd_rd_x;
          wr_y_nx = brd_rd_y;
          wr_data_nx = current_player ? 2'b10 : 2'b01;
          player_nx = ~current_player;
          tri_nx = (!current_player && tri_moves != 5'd31) ? tri_moves + 5'd1 : tri_moves;
          cir_nx = (current_player && cir_moves != 5'd31) ? cir_moves + 5'd1 : cir_moves;
        end else rej_nx = 1'b1;
        state_nx = (tri_nx == LIM && cir_nx == LIM) ? DONE : WAIT_COORD;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      brd_rd_x <= '0;
      brd_rd_y <= '0;
      brd_wr_x <= '0;
      brd_wr_y <= '0;
      brd_wr_data <= '0;
      brd_we <= 1'b0;
      move_accepted <= 1'b0;
      move_rejected <= 1'b0;
      current_player <= 1'b0;
      tri_moves <= '0;
      cir_moves <= '0;
    end else begin
      state <= state_nx;
      brd_rd_x <= rd_x_nx;
      brd_rd_y <= rd_y_nx;
      brd_wr_x <= wr_x_nx;
      brd_wr_y <= wr_y_nx;
      brd_wr_data <= wr_data_nx;
      brd_we <= we_nx;
      move_accepted <= acc_nx;
      move_rejected <= rej_nx;
      current_player <= player_nx;
      tri_moves <= tri_nx;
      cir_moves <= cir_nx;
    end
endmodule

// File: tb/tb_turn_controller.sv
// tb_turn_controller: scoreboard bench for turn_controller with MOVE_LIMIT=2 and TIMEOUT_CYCLES=8
module tb_turn_controller;
  logic       clk = 1'b0, reset = 1'b0, start = 1'b0, coord_valid = 1'b0;
  logic [3:0] x_in = '0, y_in = '0, brd_rd_x, brd_rd_y, brd_wr_x, brd_wr_y;
  logic [1:0] brd_rd_data = '0, brd_wr_data;
  logic       brd_we, current_player, move_accepted, move_rejected, game_over, timeout;
  logic [4:0] tri_moves, cir_moves;
  logic [2:0] fsm_state;
  int checks = 0, failures = 0;
  logic m_player = 1'b0;
  logic [4:0] m_tri = '0, m_cir = '0;
  typedef struct {
    logic       acc;
    logic [3:0] x, y;
    logic [1:0] d;
    logic       p;
    logic [4:0] t, c;
    logic       go;
  } exp_t;
  exp_t q[$];
  logic [36:0] all_out;
  assign all_out = {fsm_state, current_player, move_accepted, move_rejected, brd_we, tri_moves, cir_moves,
                    game_over, timeout, brd_rd_x, brd_rd_y, brd_wr_x, brd_wr_y, brd_wr_data};
  always #5 clk = ~clk;
  turn_controller #(.BOARD_DIM(10), .MOVE_LIMIT(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .start(start), .coord_valid(coord_valid), .x_in(x_in), .y_in(y_in),
    .brd_rd_x(brd_rd_x), .brd_rd_y(brd_rd_y), .brd_rd_data(brd_rd_data), .brd_we(brd_we),
    .brd_wr_x(brd_wr_x), .brd_wr_y(brd_wr_y), .brd_wr_data(brd_wr_data), .current_player(current_player),
    .move_accepted(move_accepted), .move_rejected(move_rejected), .tri_moves(tri_moves), .cir_moves(cir_moves),
    .game_over(game_over), .timeout(timeout), .fsm_state(fsm_state));

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    m_player = 1'b0;
    m_tri = '0;
    m_cir = '0;
  endtask

  task automatic do_move(input logic [3:0] x, input logic [3:0] y, input logic [1:0] d, input bit poke);
    exp_t e, got;
    int k;
    bit seen;
    e.acc = x < 10 && y < 10 && d == 2'b00;
    e.x = x;
    e.y = y;
    e.d = m_player ? 2'b10 : 2'b01;
    if (e.acc) begin
      if (m_player) m_cir++;
      else m_tri++;
      m_player = ~m_player;
    end
    e.p = m_player;
    e.t = m_tri;
    e.c = m_cir;
    e.go = m_tri == 2 && m_cir == 2;
    q.push_back(e);
    @(negedge clk) begin coord_valid = 1'b1; x_in = x; y_in = y; brd_rd_data = d; end
    seen = 0;
    k = 0;
    while (!seen && k < 8) begin
      @(negedge clk);
      k++;
      coord_valid = poke && k < 3;
      if (k == 1) begin x_in = 4'd0; y_in = 4'd0; end
      seen = move_accepted || move_rejected;
    end
    checks++;
    if (!seen || k != 3) begin
      failures++;
      $display("FAIL latency(%0d,%0d): got %0d cycles (seen=%0b), required 3", x, y, k, seen);
    end
    got = q.pop_front();
    checks++;
    if ({move_accepted, move_rejected, brd_we} !== {got.acc, !got.acc, got.acc}) begin
      failures++;
      $display("FAIL result(%0d,%0d): acc/rej/we=%b%b%b required %b%b%b", x, y, move_accepted, move_rejected, brd_we,
               got.acc, !got.acc, got.acc);
    end
    if (got.acc) begin
      checks++;
      if ({brd_wr_x, brd_wr_y, brd_wr_data} !== {got.x, got.y, got.d}) begin
        failures++;
        $display("FAIL write(%0d,%0d): wr=(%0d,%0d) data=%b required (%0d,%0d) %b", x, y, brd_wr_x, brd_wr_y,
                 brd_wr_data, got.x, got.y, got.d);
      end
    end
    checks++;
    if ({current_player, tri_moves, cir_moves, game_over, fsm_state} !== {got.p, got.t, got.c, got.go, got.go ? 3'd4 : 3'd1}) begin
      failures++;
      $display("FAIL status(%0d,%0d): p=%b tri=%0d cir=%0d go=%b st=%0d required p=%b tri=%0d cir=%0d go=%b", x, y,
               current_player, tri_moves, cir_moves, game_over, fsm_state, got.p, got.t, got.c, got.go);
    end
    @(negedge clk);
    checks++;
    if ({move_accepted, move_rejected, brd_we} !== 3'b000) begin
      failures++;
      $display("FAIL strobe_width(%0d,%0d): acc/rej/we=%b%b%b required 000", x, y, move_accepted, move_rejected, brd_we);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL reset_outputs: got %h required 0", all_out); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (fsm_state !== 3'd0) begin failures++; $display("FAIL reset_idle: state=%0d required 0", fsm_state); end
    pulse_start();
    checks++;
    if ({fsm_state, current_player} !== {3'd1, 1'b0}) begin
      failures++;
      $display("FAIL start: state=%0d p=%b required 1 0", fsm_state, current_player);
    end
  endtask

  task automatic test_legal();
    do_move(4'd3, 4'd4, 2'b00, 0);
  endtask

  task automatic test_illegal();
    do_move(4'd5, 4'd5, 2'b01, 0);
    do_move(4'd12, 4'd2, 2'b00, 0);
    do_move(4'd2, 4'd10, 2'b00, 0);
  endtask

  task automatic test_ignore_busy();
    int bad = 0;
    do_move(4'd1, 4'd1, 2'b00, 1);
    repeat (3) begin
      @(negedge clk);
      if (move_accepted || move_rejected || brd_we || fsm_state != 3'd1) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL ignore_busy: %0d bad cycles required 0", bad); end
  endtask

  task automatic test_game_over();
    int bad = 0;
    do_move(4'd2, 4'd2, 2'b00, 0);
    do_move(4'd7, 4'd7, 2'b00, 0);
    @(negedge clk) begin coord_valid = 1'b1; x_in = 4'd6; y_in = 4'd6; brd_rd_data = 2'b00; end
    @(negedge clk) coord_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (move_accepted || move_rejected || brd_we || fsm_state != 3'd4 || !game_over) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL done_ignore: %0d bad cycles required 0", bad); end
    pulse_start();
    checks++;
    if ({fsm_state, tri_moves, cir_moves, current_player, game_over} !== {3'd1, 5'd0, 5'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL restart: st=%0d tri=%0d cir=%0d p=%b go=%b required 1 0 0 0 0", fsm_state, tri_moves,
               cir_moves, current_player, game_over);
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    do_move(4'd0, 4'd9, 2'b00, 0);
    @(negedge clk) begin coord_valid = 1'b1; x_in = 4'd8; y_in = 4'd8; brd_rd_data = 2'b00; end
    @(negedge clk) begin coord_valid = 1'b0; reset = 1'b0; end
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL reset_mid: got %h required 0", all_out); end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (all_out != '0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL reset_abort: %0d bad cycles required 0", bad); end
    pulse_start();
  endtask

  task automatic test_timeout();
`ifdef TURN_TIMEOUT_EN
    int k = 0;
    bit seen = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      seen = timeout;
    end
    checks++;
    if (!seen || k != 8) begin failures++; $display("FAIL timeout_delay: got %0d (seen=%0b) required 8", k, seen); end
    checks++;
    if ({current_player, tri_moves, fsm_state} !== {1'b1, 5'd0, 3'd1}) begin
      failures++;
      $display("FAIL timeout_effect: p=%b tri=%0d st=%0d required 1 0 1", current_player, tri_moves, fsm_state);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_width: got %b required 0", timeout); end
`else
    int bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (timeout || current_player || fsm_state != 3'd1) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL no_timeout: %0d bad cycles required 0", bad); end
`endif
  endtask

  initial begin
    test_reset();
    test_legal();
    test_illegal();
    test_ignore_busy();
    test_game_over();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
